mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 10, memory word address width; DATA_W, default 16, memory data width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU access request; held with its fields stable until cpu_gnt.
REQ-005 cpu_wr  in  1  1=write, 0=read.
REQ-006 cpu_ind  in  1  1=indirect; memory[cpu_addr] supplies the effective address.
REQ-007 cpu_addr  in  ADDR_W  CPU address.
REQ-008 cpu_wdata  in  DATA_W  CPU write data.
REQ-009 cpu_gnt  out  1  one-cycle pulse: CPU request accepted.
REQ-010 cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
REQ-011 cpu_rdata  out  DATA_W  CPU read data; holds until the next CPU read completes.
REQ-012 hst_req, hst_wr, hst_addr, hst_wdata, hst_gnt, hst_rvalid, hst_rdata: host/loader port, same widths and rules as CPU port, direct access only.
REQ-013 mem_en  out  1  memory access strobe, registered.
REQ-014 mem_we  out  1  memory write enable, registered, valid only with mem_en.
REQ-015 mem_addr  out  ADDR_W  memory address, registered.
REQ-016 mem_wdata  out  DATA_W  memory write data, registered.
REQ-017 mem_rdata  in  DATA_W  synchronous-read memory output, valid in the cycle after the edge that samples mem_en=1.

Function
REQ-018 FSM states SHALL be IDLE, ACC1, WAIT1, ACC2, WAIT2.
REQ-019 IDLE: at edge E0 with any req high, SHALL select one owner, latch its wr/ind/addr/wdata, pulse its gnt for cycle E0-E1, drive mem_en=1, mem_addr=addr, mem_we=wr&~ind, mem_wdata=wdata, go to ACC1.
REQ-020 Arbitration SHALL be round-robin: if both request, grant the port not granted last; a single requester is granted immediately.
REQ-021 ACC1: mem_en SHALL drop at next edge; direct write -> IDLE; otherwise -> WAIT1.
REQ-022 WAIT1, direct read: at edge, owner rdata<=mem_rdata, owner rvalid=1 for one cycle, -> IDLE.
REQ-023 WAIT1, indirect: at edge, mem_addr<=mem_rdata[ADDR_W-1:0] (upper bits ignored), mem_en=1, mem_we=wr, -> ACC2.
REQ-024 ACC2: mem_en drops at next edge; write -> IDLE; read -> WAIT2.
REQ-025 WAIT2: at edge, owner rdata<=mem_rdata, rvalid pulse, -> IDLE.
REQ-026 Latency from accept edge E0: direct write IDLE at E1; direct read rvalid high E2-E3; indirect write IDLE at E3; indirect read rvalid high E4-E5.
REQ-027 Requests are accepted only in IDLE; a req dropped before gnt SHALL have no effect.
REQ-028 Non-owner outputs (gnt, rvalid, rdata) SHALL not change during another port's transaction.
REQ-029 Address wrap: pointer is taken modulo 2^ADDR_W; address 1023 is legal, no carry.

Reset
REQ-030 On rst: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, both gnt=0, both rvalid=0, both rdata=0, last-granted=host (CPU wins first tie).
REQ-031 rst mid-transaction SHALL abort it: no rvalid issued, mem_en=0 from the reset edge, no pending write retried.

Structure
REQ-032 Shared package cpu_mem_pkg SHALL hold ADDR_W, DATA_W, the FSM state enum and the owner encoding (OWN_CPU, OWN_HST).
REQ-033 Two-way round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], last, grant one-hot); everything else stays in mem_arbiter.

Verification
REQ-034 CPU direct read addr 0x191, mem[0x191]=0x1234 -> cpu_gnt at E0, cpu_rvalid with cpu_rdata=0x1234 at E2-E3, hst outputs unchanged.
REQ-035 CPU indirect read addr 0x010, mem[0x010]=0xFC5A, mem[0x05A]=0xBEEF -> second mem_addr=0x05A (upper bits dropped), cpu_rdata=0xBEEF at E4-E5.
REQ-036 Host write addr 0x3FF data 0xA5A5, then CPU read 0x3FF -> mem_we pulse at 0x3FF, CPU reads 0xA5A5.
REQ-037 cpu_req and hst_req held high for four transactions -> grants alternate CPU, host, CPU, host.
REQ-038 rst asserted in WAIT1 of a CPU indirect read -> no cpu_rvalid, all outputs at reset values next cycle, new request accepted afterward.
REQ-039 Back-to-back CPU direct writes to 0x192, 0x193 -> second cpu_gnt exactly two cycles after first, both locations written.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU/host memory arbiter: default widths,
// the sequencing FSM state set and the port owner encoding.
package cpu_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC1  = 3'd1,
    WAIT1 = 3'd2,
    ACC2  = 3'd3,
    WAIT2 = 3'd4
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_HST = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. Bit 0 is the CPU, bit 1 the host.
// A lone requester wins outright; on a tie the port not granted last wins.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] grant
);

  // one-hot grant from the current requests and the previous winner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_CPU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between a CPU port (direct or
// indirect access) and a host/loader port (direct only).
//
// state | meaning
// IDLE  | waiting for a request; accepts one, issues the first access
// ACC1  | first access in flight at the memory
// WAIT1 | first read data on mem_rdata (result or pointer)
// ACC2  | indirect access to the effective address in flight
// WAIT2 | indirect read data on mem_rdata
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic              cpu_ind,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              hst_req,
  input  logic              hst_wr,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [DATA_W-1:0] hst_wdata,
  output logic              hst_gnt,
  output logic              hst_rvalid,
  output logic [DATA_W-1:0] hst_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_n;
  owner_e            owner_q, owner_n;
  owner_e            last_q, last_n;
  logic              wr_q, wr_n;
  logic              ind_q, ind_n;
  logic              mem_en_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              cpu_gnt_n, hst_gnt_n;
  logic              cpu_rvalid_n, hst_rvalid_n;
  logic [DATA_W-1:0] cpu_rdata_n, hst_rdata_n;
  logic [1:0]        grant;

  rr_arb2 u_rr_arb2 (
    .req   ({hst_req, cpu_req}),
    .last  (last_q),
    .grant (grant)
  );

  // state and all registered outputs; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      last_q     <= OWN_HST;
      wr_q       <= 1'b0;
      ind_q      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      hst_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      hst_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      hst_rdata  <= '0;
    end else begin
      state_q    <= state_n;
      owner_q    <= owner_n;
      last_q     <= last_n;
      wr_q       <= wr_n;
      ind_q      <= ind_n;
      mem_en     <= mem_en_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      cpu_gnt    <= cpu_gnt_n;
      hst_gnt    <= hst_gnt_n;
      cpu_rvalid <= cpu_rvalid_n;
      hst_rvalid <= hst_rvalid_n;
      cpu_rdata  <= cpu_rdata_n;
      hst_rdata  <= hst_rdata_n;
    end
  end

  // next state and next register values; strobes default low, data holds
  always_comb begin
    state_n      = state_q;
    owner_n      = owner_q;
    last_n       = last_q;
    wr_n         = wr_q;
    ind_n        = ind_q;
    mem_en_n     = 1'b0;
    mem_we_n     = 1'b0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    cpu_gnt_n    = 1'b0;
    hst_gnt_n    = 1'b0;
    cpu_rvalid_n = 1'b0;
    hst_rvalid_n = 1'b0;
    cpu_rdata_n  = cpu_rdata;
    hst_rdata_n  = hst_rdata;

    case (state_q)
      IDLE: begin
        if (grant[0]) begin
          owner_n     = OWN_CPU;
          last_n      = OWN_CPU;
          wr_n        = cpu_wr;
          ind_n       = cpu_ind;
          cpu_gnt_n   = 1'b1;
          mem_en_n    = 1'b1;
          mem_we_n    = cpu_wr & ~cpu_ind;
          mem_addr_n  = cpu_addr;
          mem_wdata_n = cpu_wdata;
          state_n     = ACC1;
        end else if (grant[1]) begin
          owner_n     = OWN_HST;
          last_n      = OWN_HST;
          wr_n        = hst_wr;
          ind_n       = 1'b0;
          hst_gnt_n   = 1'b1;
          mem_en_n    = 1'b1;
          mem_we_n    = hst_wr;
          mem_addr_n  = hst_addr;
          mem_wdata_n = hst_wdata;
          state_n     = ACC1;
        end
      end
      ACC1: state_n = (wr_q && !ind_q) ? IDLE : WAIT1;
      WAIT1: begin
        if (ind_q) begin
          // pointer word: only the low address bits are meaningful
          mem_en_n   = 1'b1;
          mem_we_n   = wr_q;
          mem_addr_n = mem_rdata[ADDR_W-1:0];
          state_n    = ACC2;
        end else begin
          if (owner_q == OWN_CPU) begin
            cpu_rvalid_n = 1'b1;
            cpu_rdata_n  = mem_rdata;
          end else begin
            hst_rvalid_n = 1'b1;
            hst_rdata_n  = mem_rdata;
          end
          state_n = IDLE;
        end
      end
      ACC2: state_n = wr_q ? IDLE : WAIT2;
      WAIT2: begin
        if (owner_q == OWN_CPU) begin
          cpu_rvalid_n = 1'b1;
          cpu_rdata_n  = mem_rdata;
        end else begin
          hst_rvalid_n = 1'b1;
          hst_rdata_n  = mem_rdata;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of directed transactions,
// hand-written multi-cycle sequences, then random traffic checked against
// a word-level memory model.
module tb_mem_arbiter;
  import cpu_mem_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_wr, cpu_ind;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          hst_req, hst_wr;
  logic [AW-1:0] hst_addr;
  logic [DW-1:0] hst_wdata;
  logic          hst_gnt, hst_rvalid;
  logic [DW-1:0] hst_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_ind(cpu_ind),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .hst_req(hst_req), .hst_wr(hst_wr), .hst_addr(hst_addr),
    .hst_wdata(hst_wdata), .hst_gnt(hst_gnt), .hst_rvalid(hst_rvalid),
    .hst_rdata(hst_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // synchronous-read memory attached to the DUT, with a backdoor load port
  logic [DW-1:0] mem [0:1023];
  logic          bd_en;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse counters and memory access log, sampled shortly after each edge
  int cpu_gnt_cnt = 0, hst_gnt_cnt = 0, cpu_rv_cnt = 0, hst_rv_cnt = 0;
  logic [AW:0] acc_q[$];
  always @(posedge clk) begin
    #2;
    if (cpu_gnt)    cpu_gnt_cnt++;
    if (hst_gnt)    hst_gnt_cnt++;
    if (cpu_rvalid) cpu_rv_cnt++;
    if (hst_rvalid) hst_rv_cnt++;
    if (mem_en)     acc_q.push_back({mem_we, mem_addr});
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // word-level reference memory
  logic [DW-1:0] ref_mem [0:1023];

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a;
    bd_data = d;
    bd_en   = 1'b1;
    @(posedge clk);
    #1 bd_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // what a transaction must return and which accesses it must issue
  function automatic void ref_txn(input bit wr, input bit ind, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d, output logic [DW-1:0] rd,
                                  output int n_acc, output logic [AW:0] acc0,
                                  output logic [AW:0] acc1);
    logic [AW-1:0] ea;
    ea    = ind ? ref_mem[a][AW-1:0] : a;
    n_acc = ind ? 2 : 1;
    acc0  = {wr & ~ind, a};
    acc1  = {wr, ea};
    rd    = ref_mem[ea];
    if (wr) ref_mem[ea] = d;
  endfunction

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_strobes"}, {58'd0, cpu_gnt, hst_gnt, cpu_rvalid, hst_rvalid, mem_en, mem_we}, 64'd0);
    chk({nm, "_mem_bus"}, {38'd0, mem_addr, mem_wdata}, 64'd0);
    chk({nm, "_rdata"}, {32'd0, cpu_rdata, hst_rdata}, 64'd0);
  endtask

  task automatic do_txn(input bit port, input bit wr, input bit ind, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string nm, input bit use_exp,
                        input logic [DW-1:0] exp_tbl);
    logic [DW-1:0] rd_exp, o_rdata, got_rdata;
    logic [AW:0]   acc0, acc1;
    int            n_acc, o_gnt, o_rv, s_rv, g;
    bit            got;
    ref_txn(wr, ind, a, d, rd_exp, n_acc, acc0, acc1);
    @(negedge clk);
    acc_q.delete();
    o_gnt   = port ? cpu_gnt_cnt : hst_gnt_cnt;
    o_rv    = port ? cpu_rv_cnt  : hst_rv_cnt;
    s_rv    = port ? hst_rv_cnt  : cpu_rv_cnt;
    o_rdata = port ? cpu_rdata   : hst_rdata;
    if (!port) begin
      cpu_wr = wr; cpu_ind = ind; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    end else begin
      hst_wr = wr; hst_addr = a; hst_wdata = d; hst_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (port ? hst_gnt : cpu_gnt) begin got = 1'b1; break; end
    end
    cpu_req = 1'b0;
    hst_req = 1'b0;
    if (!got) begin
      timeout({nm, "_gnt"});
      return;
    end
    g = cyc;
    if (!wr) begin
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (port ? hst_rvalid : cpu_rvalid) begin got = 1'b1; break; end
      end
      if (!got) timeout({nm, "_rvalid"});
      else begin
        got_rdata = port ? hst_rdata : cpu_rdata;
        chk({nm, "_latency"}, 64'(cyc - g), ind ? 64'd4 : 64'd2);
        chk({nm, "_rdata"}, {48'd0, got_rdata}, {48'd0, rd_exp});
        if (use_exp) chk({nm, "_rdata_tbl"}, {48'd0, got_rdata}, {48'd0, exp_tbl});
      end
    end else begin
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    chk({nm, "_acc_cnt"}, 64'(acc_q.size()), 64'(n_acc));
    if (acc_q.size() > 0) chk({nm, "_acc0"}, 64'(acc_q[0]), 64'(acc0));
    if (acc_q.size() > 1) chk({nm, "_acc1"}, 64'(acc_q[1]), 64'(acc1));
    if (wr) chk({nm, "_no_rvalid"}, 64'((port ? hst_rv_cnt : cpu_rv_cnt) - s_rv), 64'd0);
    chk({nm, "_iso"},
        {16'(( port ? cpu_gnt_cnt : hst_gnt_cnt) - o_gnt),
         16'(( port ? cpu_rv_cnt  : hst_rv_cnt)  - o_rv),
         16'd0, port ? cpu_rdata : hst_rdata},
        {32'd0, 16'd0, o_rdata});
  endtask

  typedef struct {
    bit            port;
    bit            wr;
    bit            ind;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int g1, g2, c0, h0;
    bit got;
    bit exp_own, last_own;
    bit own_q[$];

    tbl[0] = '{1'b0, 1'b0, 1'b0, 10'h191, 16'h0000, 16'h1234};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 10'h010, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 10'h3FF, 16'hA5A5, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 10'h3FF, 16'h0000, 16'hA5A5};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 10'h191, 16'h0000, 16'h1234};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 10'h010, 16'h7777, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 10'h05A, 16'h0000, 16'h7777};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 10'h011, 16'h0000, 16'hA5A5};

    rst = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_data = '0;
    cpu_req = 0; cpu_wr = 0; cpu_ind = 0; cpu_addr = '0; cpu_wdata = '0;
    hst_req = 0; hst_wr = 0; hst_addr = '0; hst_wdata = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");

    for (int i = 0; i < 1024; i++) preload(AW'(i), DW'($urandom));
    preload(10'h191, 16'h1234);
    preload(10'h010, 16'hFC5A);
    preload(10'h05A, 16'hBEEF);
    preload(10'h011, 16'hF3FF);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].port, tbl[i].wr, tbl[i].ind, tbl[i].addr, tbl[i].wdata,
             $sformatf("tbl%0d", i), !tbl[i].wr, tbl[i].exp);

    // back-to-back CPU direct writes: next grant two cycles after the first
    @(negedge clk);
    cpu_wr = 1; cpu_ind = 0; cpu_addr = 10'h192; cpu_wdata = 16'h1111; cpu_req = 1;
    g1 = 0; g2 = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cpu_gnt) begin got = 1; break; end
    end
    g1 = cyc;
    cpu_addr = 10'h193; cpu_wdata = 16'h2222;
    if (got) begin
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (cpu_gnt) begin got = 1; break; end
      end
    end
    g2 = cyc;
    cpu_req = 0;
    if (!got) timeout("b2b_gnt");
    else chk("b2b_spacing", 64'(g2 - g1), 64'd2);
    repeat (3) @(posedge clk);
    ref_mem[10'h192] = 16'h1111;
    ref_mem[10'h193] = 16'h2222;
    do_txn(1'b0, 1'b0, 1'b0, 10'h192, 16'h0, "b2b_rd0", 1'b1, 16'h1111);
    do_txn(1'b1, 1'b0, 1'b0, 10'h193, 16'h0, "b2b_rd1", 1'b1, 16'h2222);

    // host request raised and dropped while busy must leave no trace
    @(negedge clk);
    cpu_wr = 0; cpu_ind = 0; cpu_addr = 10'h191; cpu_req = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cpu_gnt) begin got = 1; break; end
    end
    cpu_req = 0;
    c0 = cpu_rv_cnt; h0 = hst_gnt_cnt;
    hst_wr = 1; hst_addr = 10'h300; hst_wdata = 16'hDEAD; hst_req = 1;
    @(posedge clk); #1 hst_req = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    if (!got) timeout("drop_cpu_gnt");
    chk("drop_no_hst_gnt", 64'(hst_gnt_cnt - h0), 64'd0);
    chk("drop_cpu_rv", 64'(cpu_rv_cnt - c0), 64'd1);
    chk("drop_cpu_rdata", {48'd0, cpu_rdata}, 64'h1234);
    do_txn(1'b1, 1'b0, 1'b0, 10'h300, 16'h0, "drop_rd", 1'b0, 16'h0);

    // reset during WAIT1 of a CPU indirect read aborts it
    @(negedge clk);
    cpu_wr = 0; cpu_ind = 1; cpu_addr = 10'h010; cpu_req = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cpu_gnt) begin got = 1; break; end
    end
    cpu_req = 0; cpu_ind = 0;
    if (!got) timeout("rst_gnt");
    c0 = cpu_rv_cnt;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 chk_reset_outputs("midrst");
    rst = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_rvalid", 64'(cpu_rv_cnt - c0), 64'd0);
    do_txn(1'b0, 1'b0, 1'b0, 10'h191, 16'h0, "midrst_after", 1'b1, 16'h1234);

    // both ports requesting continuously: grants alternate, CPU first
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    cpu_wr = 0; cpu_ind = 0; cpu_addr = 10'h191; cpu_req = 1;
    hst_wr = 0; hst_addr = 10'h3FF; hst_req = 1;
    for (int i = 0; i < 60 && own_q.size() < 4; i++) begin
      @(posedge clk); #1;
      if (cpu_gnt) own_q.push_back(1'b0);
      if (hst_gnt) own_q.push_back(1'b1);
    end
    cpu_req = 0; hst_req = 0;
    repeat (6) @(posedge clk);
    if (own_q.size() < 4) timeout("rr_grants");
    last_own = 1'b1;
    for (int k = 0; k < own_q.size() && k < 4; k++) begin
      exp_own  = ~last_own;
      last_own = exp_own;
      chk($sformatf("rr_grant%0d", k), 64'(own_q[k]), 64'(exp_own));
    end

    // random single-port traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      bit p, w, ind;
      p   = 1'($urandom);
      w   = 1'($urandom);
      ind = p ? 1'b0 : 1'($urandom);
      do_txn(p, w, ind, AW'($urandom), DW'($urandom), $sformatf("rnd%0d", n), 1'b0, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
